fpmul_arbiter: RTL and testbench
================================

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Parameters
REQ-001 The block SHALL have parameter LAT, default 4, meaning cycles from mul_a/mul_b to the matching mul_z on the external multiplier pipeline; legal range 1..15.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each, requester has an operand pair.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each, combinational grant; a transfer occurs when valid and ready are both high.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 32 each, IEEE-754 single operands.
REQ-007 The block SHALL have ports mul_a, mul_b, output, 32 each, registered operands to the multiplier FP_A/FP_B.
REQ-008 The block SHALL have port mul_z, input, 32, multiplier result.
REQ-009 The block SHALL have ports rsp0_valid, rsp1_valid, output, 1 each, one-cycle result strobe per requester.
REQ-010 The block SHALL have port rsp_z, output, 32, registered result shared by both responses.
REQ-011 The block SHALL have port outstanding, output, 5, count of issued but not yet responded operations.
REQ-012 The block SHALL have port idle, output, 1, high when outstanding is 0.

Function
REQ-013 Arbitration SHALL be round-robin with a 1-bit priority pointer ptr; at most one ready SHALL be high per cycle.
- Both valid: grant requester ptr.
- One valid: grant it.
- Neither valid: no grant, ptr unchanged.
REQ-014 After any grant, ptr SHALL point to the non-granted requester.
REQ-015 req*_ready SHALL depend only on req*_valid and ptr, with no path from mul_z.
REQ-016 On a transfer in cycle t, mul_a/mul_b SHALL hold the granted operands from edge t+1 until the next transfer.
REQ-017 Without a transfer, mul_a/mul_b SHALL hold their previous values.
REQ-018 A tag shift register of depth LAT+1 SHALL carry {valid, requester id}, entering at the transfer edge and advancing every cycle.
REQ-019 When the tag output is valid, the block SHALL register rsp_z <= mul_z and pulse rspN_valid for the tagged requester.
- This SHALL occur exactly LAT+2 cycles after the transfer cycle.
- With LAT=4, the response appears 6 cycles after the transfer.
REQ-020 rsp_z SHALL hold its last value when no response is pending; rsp0_valid and rsp1_valid SHALL never be high together.
REQ-021 Responses SHALL be returned in issue order; there is no response backpressure, so requesters SHALL accept every strobe.
REQ-022 outstanding SHALL update as follows:
- +1 on a transfer.
- -1 on a response.
- Unchanged when both occur in the same cycle.
- Maximum value LAT+2; it SHALL never wrap.
REQ-023 Throughput SHALL be one transfer per cycle, sustained indefinitely.
REQ-024 The block SHALL not inspect operand or result contents; special values (NaN, INF, zero) pass through unmodified.

Reset
REQ-025 While rst is high at an edge, the block SHALL clear:
- all tag valid bits; rsp0_valid and rsp1_valid to 0;
- ptr to 0 and outstanding to 0;
- mul_a, mul_b and rsp_z to 32'h0.
REQ-026 During the rst cycle, req0_ready and req1_ready SHALL be 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; their results SHALL never produce response strobes.
REQ-028 The first grant after reset SHALL go to requester 0 when both requesters are valid.

Verification
REQ-029 Single op, LAT=4: req0 a=32'h3FC00000 (1.5), b=32'h40000000 (2.0) at cycle 0, with a model multiplier -> rsp0_valid at cycle 6, rsp_z=32'h40400000, outstanding 1 during cycles 1-6 then 0.
REQ-030 Both requesters valid continuously for 8 cycles after reset -> grants alternate 0,1,0,1...; responses alternate rsp0/rsp1 on 8 consecutive cycles starting 6 cycles after the first grant.
REQ-031 Only req1 valid for 3 cycles, then both valid -> req1 granted 3 times, then req0 granted next (ptr=0).
REQ-032 rst asserted 2 cycles after 3 back-to-back issues -> no rsp strobes ever appear for them; outstanding=0, idle=1 after reset.
REQ-033 Back-to-back full throughput for 20 cycles -> outstanding saturates at 6 (LAT+2) without wrap; the ordering check passes.
REQ-034 Operand pair 32'h7F800000 x 32'h00000000 -> forwarded unchanged on mul_a/mul_b; whatever mul_z the model multiplier returns (NaN) is delivered unchanged on rsp_z.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a fixed-latency FP multiplier.
// Results are matched back to their requester through a latency-aligned tag pipe.
module fpmul_arbiter #(
    parameter int unsigned LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_z,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_z,
    output logic [4:0]  outstanding,
    output logic        idle
);

    localparam logic [4:0] OUT_MAX = 5'(LAT + 2);

    logic         ptr;
    logic         grant0;
    logic         grant1;
    logic         xfer;
    logic         rsp_any;
    logic [LAT:0] tag_v;
    logic [LAT:0] tag_id;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
            grant0 = !ptr;
            grant1 = ptr;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign rsp_any    = rsp0_valid | rsp1_valid;
    assign idle       = (outstanding == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= 1'b0;
            mul_a       <= 32'h0;
            mul_b       <= 32'h0;
            tag_v       <= '0;
            tag_id      <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp_z       <= 32'h0;
            outstanding <= 5'd0;
        end else begin
            if (xfer) begin
                mul_a <= grant1 ? req1_a : req0_a;
                mul_b <= grant1 ? req1_b : req0_b;
                ptr   <= !grant1;
            end

            // tag[LAT] lines up with mul_z for the op issued LAT+1 edges ago
            tag_v  <= {tag_v[LAT-1:0], xfer};
            tag_id <= {tag_id[LAT-1:0], grant1};

            rsp0_valid <= tag_v[LAT] && !tag_id[LAT];
            rsp1_valid <= tag_v[LAT] && tag_id[LAT];
            if (tag_v[LAT]) begin
                rsp_z <= mul_z;
            end

            unique case ({xfer, rsp_any})
                2'b10: begin
                    if (outstanding != OUT_MAX) begin
                        outstanding <= outstanding + 5'd1;
                    end
                end
                2'b01: begin
                    if (outstanding != 5'd0) begin
                        outstanding <= outstanding - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: directed scenarios plus random traffic checked
// every cycle against an issue-queue model of requests and responses.
module tb_fpmul_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [31:0] mul_a, mul_b, mul_z;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_z;
    logic [4:0]  outstanding;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fpmul_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_z(rsp_z), .outstanding(outstanding), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // stand-in multiplier: exact for the directed cases, a fixed hash otherwise
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
        if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) ||
            (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0)) return 32'h7FC00000;
        return {a[31] ^ b[31], (a[30:0] ^ {b[15:0], b[30:16]}) + 31'd12345};
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit          id;
        int          due;
        logic [31:0] z;
    } op_t;

    op_t         q[$];
    bit          mptr;
    bit          started = 0;
    logic [31:0] exp_ma, exp_mb, exp_rz;

    // model: every issued op owes one response exactly LAT+2 cycles later
    always @(negedge clk) begin
        bit g0, g1, e0, e1;
        int n_out;
        g0 = 0;
        g1 = 0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                g0 = (mptr == 0);
                g1 = (mptr == 1);
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        if (started) begin
            n_out = q.size();
            e0 = 0;
            e1 = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e0 = (q[0].id == 0);
                e1 = (q[0].id == 1);
                exp_rz = q[0].z;
                void'(q.pop_front());
            end
            chk("req0_ready", 32'(req0_ready), 32'(g0));
            chk("req1_ready", 32'(req1_ready), 32'(g1));
            chk("mul_a", mul_a, exp_ma);
            chk("mul_b", mul_b, exp_mb);
            chk("rsp0_valid", 32'(rsp0_valid), 32'(e0));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(e1));
            chk("rsp_z", rsp_z, exp_rz);
            chk("outstanding", 32'(outstanding), 32'(n_out));
            chk("idle", 32'(idle), 32'(n_out == 0));
        end
        if (rst) begin
            q.delete();
            mptr = 0;
            exp_ma = 0;
            exp_mb = 0;
            exp_rz = 0;
        end else if (g0 || g1) begin
            op_t o;
            o.id  = g1;
            o.due = cyc + LAT + 2;
            o.z   = g1 ? fmul(req1_a, req1_b) : fmul(req0_a, req0_b);
            q.push_back(o);
            exp_ma = g1 ? req1_a : req0_a;
            exp_mb = g1 ? req1_b : req0_b;
            mptr = !g1;
        end
        started = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        req0_valid = 0;
        req1_valid = 0;
        tick();
        rst = 0;
    endtask

    function automatic logic [31:0] rnd_op();
        unique case ($urandom_range(0, 7))
            0: return 32'h7F800000;
            1: return 32'h00000000;
            2: return 32'h7FC00000;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int mx;
        rst = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        repeat (3) tick();
        chk("reset_out", 32'(outstanding), 32'd0);
        chk("reset_rsp_z", rsp_z, 32'h0);
        rst = 0;
        tick();

        // single op 1.5 * 2.0
        req0_valid = 1; req0_a = 32'h3FC00000; req0_b = 32'h40000000;
        #1 chk("single_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 0;
        chk("single_mul_a", mul_a, 32'h3FC00000);
        chk("single_out1", 32'(outstanding), 32'd1);
        repeat (5) tick();
        chk("single_rsp0", 32'(rsp0_valid), 32'd1);
        chk("single_rsp_z", rsp_z, 32'h40400000);
        chk("single_out6", 32'(outstanding), 32'd1);
        tick();
        chk("single_out7", 32'(outstanding), 32'd0);
        chk("single_rsp0_off", 32'(rsp0_valid), 32'd0);

        // both valid for 8 cycles: alternating grants and responses
        do_reset();
        for (int k = 0; k < 16; k++) begin
            req0_valid = (k < 8); req1_valid = (k < 8);
            req0_a = $urandom; req0_b = $urandom;
            req1_a = $urandom; req1_b = $urandom;
            #1;
            if (k < 8) chk("alt_grant0", 32'(req0_ready), 32'(k % 2 == 0));
            if (k >= 6 && k < 14) begin
                chk("alt_rsp0", 32'(rsp0_valid), 32'(k % 2 == 0));
                chk("alt_rsp1", 32'(rsp1_valid), 32'(k % 2 == 1));
            end
            tick();
        end

        // req1 alone three times, then both -> req0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req1_valid = 1; req0_valid = (k == 3);
            #1;
            if (k < 3) chk("solo_grant1", 32'(req1_ready), 32'd1);
            else chk("after_solo_grant0", 32'(req0_ready), 32'd1);
            tick();
        end
        req0_valid = 0; req1_valid = 0;

        // reset with ops in flight
        do_reset();
        req0_valid = 1;
        repeat (3) tick();
        req0_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("flush_out", 32'(outstanding), 32'd0);
        chk("flush_idle", 32'(idle), 32'd1);
        for (int k = 0; k < 10; k++) begin
            chk("flush_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
            tick();
        end

        // full throughput saturation
        do_reset();
        mx = 0;
        req0_valid = 1; req1_valid = 1;
        for (int k = 0; k < 20; k++) begin
            req0_a = $urandom; req1_a = $urandom;
            tick();
            if (int'(outstanding) > mx) mx = int'(outstanding);
        end
        req0_valid = 0; req1_valid = 0;
        chk("sat_max", 32'(mx), 32'd6);
        repeat (8) tick();

        // INF x 0 passes through untouched
        do_reset();
        req0_valid = 1; req0_a = 32'h7F800000; req0_b = 32'h00000000;
        tick();
        req0_valid = 0;
        chk("inf_mul_a", mul_a, 32'h7F800000);
        chk("inf_mul_b", mul_b, 32'h00000000);
        repeat (5) tick();
        chk("inf_rsp0", 32'(rsp0_valid), 32'd1);
        chk("inf_rsp_z", rsp_z, 32'h7FC00000);

        // random traffic with occasional resets
        for (int k = 0; k < 500; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = rnd_op(); req0_b = rnd_op();
            req1_a = rnd_op(); req1_b = rnd_op();
            tick();
        end
        rst = 0; req0_valid = 0; req1_valid = 0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
